// File: rtl/cart_pkg.sv
// Shared cartridge definitions.
// - CPU address-map region bounds (ROM0, ROMX, EXTRAM)
// - MBC register windows, selected by addr[14:13] inside 0000-7FFF
// - Read-select enum used by the one-deep read pipeline
// - Cartridge-type header codes, kept for later MBC variants
package cart_pkg;

  localparam logic [15:0] ROM0_BASE   = 16'h0000;
  localparam logic [15:0] ROM0_LAST   = 16'h3FFF;
  localparam logic [15:0] ROMX_BASE   = 16'h4000;
  localparam logic [15:0] ROMX_LAST   = 16'h7FFF;
  localparam logic [15:0] EXTRAM_BASE = 16'hA000;
  localparam logic [15:0] EXTRAM_LAST = 16'hBFFF;

  // MBC register windows, decoded from addr[14:13] when addr[15] is 0.
  localparam logic [1:0] WIN_RAM_EN  = 2'd0;  // 0000-1FFF
  localparam logic [1:0] WIN_BANK_LO = 2'd1;  // 2000-3FFF
  localparam logic [1:0] WIN_BANK_HI = 2'd2;  // 4000-5FFF
  localparam logic [1:0] WIN_MODE    = 2'd3;  // 6000-7FFF

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ROM  = 2'd1,
    SEL_RAM  = 2'd2,
    SEL_FF   = 2'd3
  } rd_sel_t;

  typedef enum logic [7:0] {
    CART_ROM_ONLY      = 8'h00,
    CART_MBC1          = 8'h01,
    CART_MBC1_RAM      = 8'h02,
    CART_MBC1_RAM_BATT = 8'h03,
    CART_MBC3          = 8'h11,
    CART_MBC5          = 8'h19
  } cart_type_t;

  function automatic logic in_rom(input logic [15:0] a);
    return (a >= ROM0_BASE) && (a <= ROMX_LAST);
  endfunction

  function automatic logic in_extram(input logic [15:0] a);
    return (a >= EXTRAM_BASE) && (a <= EXTRAM_LAST);
  endfunction

endpackage

// File: rtl/cart_mbc1_if.sv
// CPU-side cartridge bus.
// - addr, data_w, write_enable : driven by the CPU (master)
// - data_r                     : read data, valid the cycle after the address
// - data_active                : cartridge claims the current read cycle
interface cart_mbc1_if;
  logic [15:0] addr;
  logic [7:0]  data_w;
  logic        write_enable;
  logic [7:0]  data_r;
  logic        data_active;

  modport master (
    output addr, data_w, write_enable,
    input  data_r, data_active
  );

  modport slave (
    input  addr, data_w, write_enable,
    output data_r, data_active
  );
endinterface

// File: rtl/cart_mbc1_regs.sv
// MBC1 bank-control register file.
// Inputs : clk, reset (sync, active-high), write_enable, addr_hi (addr[15:13]),
//          data_w
// Outputs: ram_en, bank_lo (never 0), bank_hi, mode
module cart_mbc1_regs
  import cart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       write_enable,
  input  logic [2:0] addr_hi,
  input  logic [7:0] data_w,
  output logic       ram_en,
  output logic [4:0] bank_lo,
  output logic [1:0] bank_hi,
  output logic       mode
);

  // Upper data bits are not part of any MBC1 register field.
  logic unused_ok;
  assign unused_ok = ^data_w[7:5];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en  <= 1'b0;
      bank_lo <= 5'd1;
      bank_hi <= 2'd0;
      mode    <= 1'b0;
    end else if (write_enable && !addr_hi[2]) begin
      case (addr_hi[1:0])
        WIN_RAM_EN:  ram_en  <= (data_w[3:0] == 4'hA);
        // Only the 5-bit field is zero-checked: 0x20 and 0x00 both select 1.
        WIN_BANK_LO: bank_lo <= (data_w[4:0] == 5'd0) ? 5'd1 : data_w[4:0];
        WIN_BANK_HI: bank_hi <= data_w[1:0];
        WIN_MODE:    mode    <= data_w[0];
        default:     ;
      endcase
    end
  end

endmodule

// File: rtl/cart_mbc1.sv
// MBC1 cartridge controller.
// Ports: clk, reset (sync, active-high), bus (CPU side, slave modport),
//        rom_addr/rom_rdata (sync ROM array, 1-cycle read),
//        ram_addr/ram_wdata/ram_we/ram_rdata (sync RAM array, 1-cycle read).
// CPU writes to 0000-7FFF program the bank registers; reads of 0000-7FFF and
// A000-BFFF are mapped onto the arrays and returned one cycle later.
module cart_mbc1
  import cart_pkg::*;
#(
  parameter  int ROM_BANKS = 64,
  parameter  int RAM_BANKS = 4,
  localparam int ROM_BW    = $clog2(ROM_BANKS),
  localparam int RAM_BW    = $clog2((RAM_BANKS > 1) ? RAM_BANKS : 1),
  localparam int ROM_AW    = 14 + ROM_BW,
  localparam int RAM_AW    = 13 + RAM_BW
) (
  input  logic              clk,
  input  logic              reset,
  cart_mbc1_if.slave        bus,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata
);

  localparam logic HAS_RAM = (RAM_BANKS != 0);

  logic       ram_en;
  logic [4:0] bank_lo;
  logic [1:0] bank_hi;
  logic       mode;

  cart_mbc1_regs u_regs (
    .clk          (clk),
    .reset        (reset),
    .write_enable (bus.write_enable),
    .addr_hi      (bus.addr[15:13]),
    .data_w       (bus.data_w),
    .ram_en       (ram_en),
    .bank_lo      (bank_lo),
    .bank_hi      (bank_hi),
    .mode         (mode)
  );

  logic is_rom;
  logic is_ram;
  logic ram_ok;
  assign is_rom = in_rom(bus.addr);
  assign is_ram = in_extram(bus.addr);
  assign ram_ok = ram_en && HAS_RAM;

  // ROM bank: the lower window only sees bank_hi in mode 1; the upper window
  // always uses the full 7-bit bank. Truncating to ROM_BW bits wraps the bank
  // modulo ROM_BANKS.
  logic [6:0] rom_bank_full;
  always_comb begin
    if (bus.addr[14])
      rom_bank_full = {bank_hi, bank_lo};
    else
      rom_bank_full = mode ? {bank_hi, 5'd0} : 7'd0;
  end
  assign rom_addr = {rom_bank_full[ROM_BW-1:0], bus.addr[13:0]};

  // Bank bits above ROM_BW are dropped by design.
  logic unused_ok;
  assign unused_ok = ^rom_bank_full;

  if (RAM_BW > 0) begin : g_ram_bank
    logic [1:0] ram_bank_full;
    assign ram_bank_full = mode ? bank_hi : 2'd0;
    assign ram_addr      = {ram_bank_full[RAM_BW-1:0], bus.addr[12:0]};
  end else begin : g_ram_flat
    assign ram_addr = bus.addr[12:0];
  end

  assign ram_wdata       = bus.data_w;
  assign ram_we          = bus.write_enable && is_ram && ram_ok;
  assign bus.data_active = !bus.write_enable && (is_rom || is_ram);

  // The registered select is the whole read pipeline; the arrays supply the
  // matching 1-cycle data, so data_r is a plain mux on the select.
  rd_sel_t rd_sel;
  always_ff @(posedge clk) begin
    if (reset)                 rd_sel <= SEL_NONE;
    else if (bus.write_enable) rd_sel <= SEL_NONE;
    else if (is_rom)           rd_sel <= SEL_ROM;
    else if (is_ram)           rd_sel <= ram_ok ? SEL_RAM : SEL_FF;
    else                       rd_sel <= SEL_NONE;
  end

  // NOTE: the default assignment ahead of the case keeps this block purely
  // combinational (no latch) even if an arm is later removed.
  always_comb begin
    bus.data_r = 8'hFF;
    case (rd_sel)
      SEL_ROM: bus.data_r = rom_rdata;
      SEL_RAM: bus.data_r = ram_rdata;
      default: bus.data_r = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_cart_mbc1.sv
// Directed bench for cart_mbc1 (ROM_BANKS=64, RAM_BANKS=4).
// ROM model: byte = 5A at 0x04000, else a[7:0]+a[15:8]+a[19:16] (mod 256).
// RAM model: 32 KiB synchronous array.
module tb_cart_mbc1;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] rom_addr;
  logic [7:0]  rom_rdata;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  int tests = 0;
  int fails = 0;

  cart_mbc1_if bus ();

  cart_mbc1 #(.ROM_BANKS(64), .RAM_BANKS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .rom_addr  (rom_addr),
    .rom_rdata (rom_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [19:0] a);
    if (a == 20'h04000) return 8'h5A;
    return a[7:0] + a[15:8] + {4'h0, a[19:16]};
  endfunction

  always @(posedge clk) rom_rdata <= rom_byte(rom_addr);

  logic [7:0] ram_mem [0:32767];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Values seen during the most recent write cycle, before its clock edge.
  logic        w_ram_we;
  logic [14:0] w_ram_addr;
  logic        w_active;

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr = a; bus.data_w = d; bus.write_enable = 1'b1;
    #1;
    w_ram_we = ram_we; w_ram_addr = ram_addr; w_active = bus.data_active;
    @(posedge clk); #1;
    bus.write_enable = 1'b0;
  endtask

  // Read: captures mapping/claim in the address cycle and data_r after the edge.
  logic [19:0] r_rom_addr;
  logic [14:0] r_ram_addr;
  logic        r_active;
  logic [7:0]  r_data;

  task automatic rd(input logic [15:0] a);
    @(negedge clk);
    bus.addr = a; bus.write_enable = 1'b0;
    #1;
    r_rom_addr = rom_addr; r_ram_addr = ram_addr; r_active = bus.data_active;
    @(posedge clk); #1;
    r_data = bus.data_r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.addr = 16'h0000; bus.data_w = 8'h00; bus.write_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_r", bus.data_r, 8'hFF);
    @(negedge clk); reset = 1'b0;

    // Default mapping: bank 1 in the upper window.
    rd(16'h4000);
    check("rd4000_rom_addr", r_rom_addr, 20'h04000);
    check("rd4000_active",   r_active,   1'b1);
    check("rd4000_data",     r_data,     8'h5A);

    // bank_lo = 0 stores 1.
    wr(16'h2000, 8'h00);
    check("wr_active_low",   w_active,   1'b0);
    check("wr_data_r_ff",    bus.data_r, 8'hFF);
    rd(16'h4123);
    check("bank0_rom_addr",  r_rom_addr, 20'h04123);
    check("bank0_data",      r_data,     8'h64);
    wr(16'h2000, 8'h05);
    rd(16'h4123);
    check("bank5_rom_addr",  r_rom_addr, 20'h14123);
    check("bank5_data",      r_data,     8'h65);
    wr(16'h2000, 8'h20);
    rd(16'h4123);
    check("bank20_rom_addr", r_rom_addr, 20'h04123);
    wr(16'h2000, 8'h21);
    rd(16'h4123);
    check("bank21_rom_addr", r_rom_addr, 20'h04123);
    // New mapping is visible on the very next cycle.
    wr(16'h2000, 8'h07);
    rd(16'h4000);
    check("bank7_next_cycle", r_rom_addr, 20'h1C000);
    wr(16'h2000, 8'h05);

    // Mode 1: bank_hi reaches the lower window; 64 banks wraps bank 64 to 0.
    wr(16'h4000, 8'h02);
    wr(16'h6000, 8'h01);
    rd(16'h0010);
    check("m1_hi2_rom_addr", r_rom_addr, 20'h00010);
    check("m1_hi2_data",     r_data,     8'h10);
    rd(16'h4123);
    check("hi2_lo5_wrap",    r_rom_addr, 20'h14123);
    wr(16'h4000, 8'h01);
    rd(16'h0010);
    check("m1_hi1_rom_addr", r_rom_addr, 20'h80010);
    check("m1_hi1_data",     r_data,     8'h18);
    wr(16'h6000, 8'h00);
    rd(16'h0010);
    check("m0_hi1_rom_addr", r_rom_addr, 20'h00010);
    wr(16'h4000, 8'h00);

    // Unmapped region.
    rd(16'hC000);
    check("c000_active",     r_active,   1'b0);
    check("c000_data",       r_data,     8'hFF);

    // External RAM disabled, then enabled.
    rd(16'hA000);
    check("ramoff_active",   r_active,   1'b1);
    check("ramoff_data",     r_data,     8'hFF);
    wr(16'hA000, 8'h33);
    check("ramoff_we",       w_ram_we,   1'b0);
    wr(16'h0000, 8'h0A);
    wr(16'hA000, 8'h33);
    check("ramon_we",        w_ram_we,   1'b1);
    check("ramon_wr_addr",   w_ram_addr, 15'h0000);
    rd(16'hA000);
    check("ramon_data",      r_data,     8'h33);
    wr(16'h0000, 8'h00);
    rd(16'hA000);
    check("ramdis_data",     r_data,     8'hFF);

    // RAM banking: enable with upper nibble set (only low nibble matters).
    wr(16'h0000, 8'h1A);
    wr(16'h4000, 8'h03);
    wr(16'h6000, 8'h01);
    wr(16'hA001, 8'h77);
    check("m1_ram_we",       w_ram_we,   1'b1);
    check("m1_ram_addr",     w_ram_addr, 15'h6001);
    rd(16'hA001);
    check("m1_ram_data",     r_data,     8'h77);
    wr(16'h6000, 8'h00);
    wr(16'hA001, 8'h44);
    check("m0_ram_addr",     w_ram_addr, 15'h0001);
    rd(16'hA001);
    check("m0_ram_data",     r_data,     8'h44);
    wr(16'h6000, 8'h01);
    rd(16'hA001);
    check("m1_ram_rd_addr",  r_ram_addr, 15'h6001);
    check("m1_ram_keep",     r_data,     8'h77);

    // Reset during a read of 4000: data is FF and all registers reset.
    wr(16'h2000, 8'h05);
    @(negedge clk);
    bus.addr = 16'h4000; bus.write_enable = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_data",    bus.data_r, 8'hFF);
    check("rst_mid_rom_addr", rom_addr,  20'h04000);
    @(negedge clk); reset = 1'b0;
    rd(16'hA000);
    check("rst_ram_off",     r_data,     8'hFF);
    rd(16'h0010);
    check("rst_mode0",       r_rom_addr, 20'h00010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
